// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;      // product high half / remainder
  logic [XLEN-1:0] lo_q, lo_d;      // product low half + multiplier / quotient + dividend
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at the accept point
  logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;

  assign is_div_in = op_i[2];
  assign a_sgn_in  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_sgn_in  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg_in  = a_sgn_in && a_i[XLEN-1];
  assign b_neg_in  = b_sgn_in && b_i[XLEN-1];
  assign a_abs     = a_neg_in ? -a_i : a_i;
  assign b_abs     = b_neg_in ? -b_i : b_i;
  assign div_zero  = is_div_in && (b_i == '0);
  assign div_ovf   = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == INT_MIN) && (b_i == '1);

  // One iteration of shift-add and of restoring shift-subtract
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_tmp;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_neg;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_tmp  = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, opnd_q};
  assign prod_neg = -{hi_q, lo_q};

  // Next-state, datapath and output selection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          neg_a_d = a_neg_in;
          neg_b_d = b_neg_in;
          cnt_d   = '0;
          if (div_zero) begin
            lo_d    = '1;
            hi_d    = a_i;
            state_d = S_DONE;
          end else if (div_ovf) begin
            lo_d    = INT_MIN;
            hi_d    = '0;
            state_d = S_DONE;
          end else if (is_div_in) begin
            hi_d    = '0;
            lo_d    = a_abs;
            opnd_d  = b_abs;
            state_d = S_CALC;
          end else begin
            hi_d    = '0;
            lo_d    = b_abs;
            opnd_d  = a_abs;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_tmp[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[2]) begin
          if (neg_a_q ^ neg_b_q) {hi_d, lo_d} = prod_neg;
        end else begin
          if (neg_a_q ^ neg_b_q) lo_d = -lo_q;
          if (neg_a_q) hi_d = -hi_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        unique case (op_q)
          OP_MUL, OP_DIV, OP_DIVU:              result_d = lo_q;
          OP_MULH, OP_MULHSU, OP_MULHU:         result_d = hi_q;
          OP_REM, OP_REMU:                      result_d = hi_q;
          default:                              result_d = lo_q;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: back to idle, no pulse, result untouched
    if (flush_i) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign stall_o  = rst_ni && ((start_i && (state_q == S_IDLE)) || (busy_o && (state_q != S_DONE)));
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; the block SHALL be verified at 32 only.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  XLEN  rs1 operand (multiplicand / dividend).
REQ-007 b  input  XLEN  rs2 operand (multiplier / divisor).
REQ-008 flush  input  1  abort the in-flight operation (branch mispredict / trap).
REQ-009 busy  output  1  high while the state is not IDLE.
REQ-010 stall  output  1  pipeline hold request; equals start&IDLE OR (busy AND state != DONE).
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  XLEN  operation result; holds its last value until the next done.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE: start=1 SHALL latch op, a, b, take absolute values of signed operands per op, clear the 6-bit iteration counter, and go to CALC; start=0 SHALL stay in IDLE.
REQ-015 Special case: for DIV/DIVU/REM/REMU with b==0, IDLE SHALL go directly to DONE with quotient=all-ones (DIV, DIVU) or remainder=a (REM, REMU).
REQ-016 Special case: for DIV/REM with a=0x80000000 and b=0xFFFFFFFF, IDLE SHALL go directly to DONE with DIV=0x80000000 and REM=0.
REQ-017 CALC SHALL run exactly 32 iterations, one per cycle: multiply = radix-2 shift-add into a 64-bit product; divide = restoring shift-subtract producing a 32-bit quotient and remainder.
REQ-018 CALC SHALL go to FIX when the counter reaches 31 at the clock edge.
REQ-019 FIX SHALL apply sign correction in one cycle: negate the product if exactly one signed operand was negative (MULH: both signed; MULHSU: a only); negate the quotient if the operand signs differ (DIV); give the remainder the sign of the dividend (REM); then go to DONE.
REQ-020 Result select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-021 DONE SHALL assert done for exactly one cycle, register result, and return to IDLE; start in DONE SHALL be ignored.
REQ-022 Latency from the start-accept edge to done high: 34 cycles normally; 1 cycle for the special cases.
REQ-023 start while busy SHALL be ignored; operands SHALL not be re-sampled.
REQ-024 flush in any state SHALL force IDLE at the next edge, suppress done, and leave result unchanged; flush has priority over start in the same cycle.
REQ-025 Back-to-back: start may be accepted in the cycle after DONE (IDLE).

Reset
REQ-026 rst_n=0 SHALL immediately set state=IDLE, busy=0, stall=0, done=0, result=0, and counter=0, regardless of clk.
REQ-027 Reset deasserted mid-operation SHALL resume from IDLE, and the aborted operation SHALL produce no done.

Verification
REQ-028 MUL a=7, b=-3 (0xFFFFFFFD) -> done at cycle 34, result=0xFFFFFFEB; MULH with the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-029 DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-030 DIVU a=5, b=0 -> done one cycle after start, result=0xFFFFFFFF; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at 1-cycle latency.
REQ-031 flush pulse at CALC iteration 10 -> busy=0 next cycle, no done, result keeps its previous value; a new start then completes normally.
REQ-032 start held high during busy with changing a and b -> exactly one done, using the operands from the accept cycle.
REQ-033 rst_n asserted low at iteration 20 -> outputs reset asynchronously before the next clk edge; no done after release.
